// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 S-memory widths, device indices and arbiter state type
package rc4_pkg;
  localparam int RC4_RAM_WIDTH = 8;
  localparam int RC4_ADDR_WIDTH = 8;
  localparam int DEV_INIT = 0;
  localparam int DEV_KSA = 1;
  localparam int DEV_PRGA = 2;
  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;
endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// rr_pick: first unmasked requester at or after ptr in cyclic order
module rr_pick #(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          found
);
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (!found && i >= int'(ptr) && req[i] && !mask[i]) begin
        pick[i] = 1'b1;
        found = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (!found && i < int'(ptr) && req[i] && !mask[i]) begin
        pick[i] = 1'b1;
        found = 1'b1;
      end
  end
endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin, grant-locked sharing of the RC4 S-memory with per-device read return
module s_mem_arbiter
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH = RC4_RAM_WIDTH,
  parameter int ADDR_WIDTH = RC4_ADDR_WIDTH,
  parameter int NUM_DEVICES = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_DEVICES-1:0]            req,
  input  logic [NUM_DEVICES-1:0]            wren,
  input  logic [NUM_DEVICES*ADDR_WIDTH-1:0] dev_addr,
  input  logic [NUM_DEVICES*RAM_WIDTH-1:0]  dev_wdata,
  output logic [NUM_DEVICES-1:0]            grant,
  output logic [NUM_DEVICES-1:0]            rvalid,
  output logic [RAM_WIDTH-1:0]              rdata,
  output logic                              busy,
  output logic                              ram_wren,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [RAM_WIDTH-1:0]              ram_data,
  input  logic [RAM_WIDTH-1:0]              ram_q
);
  localparam int PW = NUM_DEVICES > 1 ? $clog2(NUM_DEVICES) : 1;
  arb_state_t state_q, state_d;
  logic [NUM_DEVICES-1:0] grant_q, grant_d, pick, pick_mask, rd_issue;
  logic [PW-1:0] ptr_q, ptr_d, own, nxt_ptr, pick_ptr;
  logic found, owner_req;
  logic [READ_LATENCY-1:0][NUM_DEVICES-1:0] pipe_q, pipe_d;
  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_DEVICES; i++)
      if (grant_q[i]) own = PW'(i);
    nxt_ptr = (int'(own) == NUM_DEVICES - 1) ? '0 : own + 1'b1;
  end
  // only the owner's own req bit decides hold, so unknowns elsewhere cannot leak in
  assign owner_req = |(grant_q & req);
  assign pick_mask = (state_q == ARB_IDLE) ? '0 : grant_q;
  assign pick_ptr = (state_q == ARB_IDLE) ? ptr_q : nxt_ptr;
  rr_pick #(.N(NUM_DEVICES), .PW(PW)) u_pick (
    .req(req),
    .mask(pick_mask),
    .ptr(pick_ptr),
    .pick(pick),
    .found(found)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    if (state_q == ARB_IDLE || !owner_req) begin
      state_d = found ? ARB_OWNED : ARB_IDLE;
      grant_d = found ? pick : '0;
      ptr_d = (state_q == ARB_OWNED) ? nxt_ptr : ptr_q;
    end
  end
  always_comb begin
    ram_wren = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    rd_issue = '0;
    for (int i = 0; i < NUM_DEVICES; i++)
      if (grant_q[i] && req[i]) begin
        ram_wren = wren[i];
        ram_addr = dev_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data = dev_wdata[i*RAM_WIDTH +: RAM_WIDTH];
        rd_issue[i] = !wren[i];
      end
    pipe_d[0] = rd_issue;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      pipe_q <= pipe_d;
    end
  assign grant = grant_q;
  assign rvalid = pipe_q[READ_LATENCY-1];
  assign rdata = ram_q;
  assign busy = |grant_q || |pipe_q;
endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: directed checks of s_mem_arbiter at read latency 1 (a) and 2 (b)
module tb_s_mem_arbiter;
  import rc4_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] req, wren;
  logic [7:0] addr0, addr1, addr2, wd0, wd1, wd2;
  logic [23:0] dev_addr, dev_wdata;
  logic [2:0] a_grant, a_rvalid, b_grant, b_rvalid;
  logic [7:0] a_rdata, a_addr, a_data, a_q, b_rdata, b_addr, b_data, b_q, b_q1;
  logic a_busy, a_wren, b_busy, b_wren;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  bit init_done = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign dev_addr = {addr2, addr1, addr0};
  assign dev_wdata = {wd2, wd1, wd0};
  s_mem_arbiter #(.READ_LATENCY(1)) a (
    .clk(clk), .reset(reset), .req(req), .wren(wren), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .grant(a_grant), .rvalid(a_rvalid), .rdata(a_rdata), .busy(a_busy),
    .ram_wren(a_wren), .ram_addr(a_addr), .ram_data(a_data), .ram_q(a_q)
  );
  s_mem_arbiter #(.READ_LATENCY(2)) b (
    .clk(clk), .reset(reset), .req(req), .wren(wren), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .grant(b_grant), .rvalid(b_rvalid), .rdata(b_rdata), .busy(b_busy),
    .ram_wren(b_wren), .ram_addr(b_addr), .ram_data(b_data), .ram_q(b_q)
  );
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'h00;
        mem_b[i] <= 8'h00;
      end
      mem_a[8'h20] <= 8'h3C;
      mem_b[8'h20] <= 8'h3C;
      mem_a[8'h03] <= 8'h77;
      mem_b[8'h03] <= 8'h77;
      init_done <= 1'b1;
    end else begin
      if (a_wren) mem_a[a_addr] <= a_data;
      if (b_wren) mem_b[b_addr] <= b_data;
    end
    a_q <= mem_a[a_addr];
    b_q1 <= mem_b[b_addr];
    b_q <= b_q1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1'b0;
    req = 3'b111;
    wren = 3'b000;
    {addr0, addr1, addr2, wd0, wd1, wd2} = '0;
    #3;
    chk("rst_grant", a_grant, 3'b000);
    chk("rst_rvalid", a_rvalid, 3'b000);
    chk("rst_wren", a_wren, 1'b0);
    tick; tick;
    chk("rst_grant_hold", a_grant, 3'b000);
    reset = 1'b1;
    tick;
    chk("rel_grant", a_grant, 3'b001);
    req = 3'b010;
    tick;
    chk("t2_grant", a_grant, 3'b010);
    wren = 3'b010; addr1 = 8'h10; wd1 = 8'hA5;
    #1;
    chk("t2_wren", a_wren, 1'b1);
    chk("t2_addr", a_addr, 8'h10);
    chk("t2_data", a_data, 8'hA5);
    chk("t2_no_rvalid", a_rvalid, 3'b000);
    tick;
    wren = 3'b000;
    #1;
    chk("t2_rd_wren", a_wren, 1'b0);
    chk("t2_rd_addr", a_addr, 8'h10);
    tick;
    chk("t2_rvalid", a_rvalid, 3'b010);
    chk("t2_rdata", a_rdata, 8'hA5);
    req = 3'b000;
    tick;
    chk("t2_idle", a_grant, 3'b000);
    chk("t2_busy", a_busy, 1'b0);
    req = 3'b100; addr2 = 8'h10;
    tick;
    chk("t3_g0", a_grant, 3'b100);
    req = 3'b101;
    #1;
    chk("t3_addr_i", a_addr, 8'h10);
    tick;
    chk("t3_g1", a_grant, 3'b100);
    chk("t3_rv_i", a_rvalid, 3'b100);
    chk("t3_rd_i", a_rdata, 8'hA5);
    addr2 = 8'h20;
    tick;
    chk("t3_g2", a_grant, 3'b100);
    chk("t3_rv_j", a_rvalid, 3'b100);
    chk("t3_rd_j", a_rdata, 8'h3C);
    req = 3'b1x1; wren = 3'b100; addr2 = 8'h10; wd2 = 8'h5A;
    #1;
    chk("t3_x_addr", a_addr, 8'h10);
    chk("t3_x_wren", a_wren, 1'b1);
    chk("t3_x_data", a_data, 8'h5A);
    tick;
    chk("t3_g3", a_grant, 3'b100);
    chk("t3_wr_norv", a_rvalid, 3'b000);
    req = 3'b101; addr2 = 8'h20; wd2 = 8'hA5;
    tick;
    chk("t3_g4", a_grant, 3'b100);
    req = 3'b001; wren = 3'b000;
    #1;
    chk("t3_drop_nowr", a_wren, 1'b0);
    tick;
    chk("t3_handoff", a_grant, 3'b001);
    addr0 = 8'h10;
    tick;
    chk("t3_swap_rv", a_rvalid, 3'b001);
    chk("t3_swap_rd", a_rdata, 8'h5A);
    req = 3'b111;
    tick;
    chk("t4_g0", a_grant, 3'b001);
    req = 3'b110;
    tick;
    chk("t4_g1", a_grant, 3'b010);
    req = 3'b111;
    tick;
    chk("t4_g1_hold", a_grant, 3'b010);
    req = 3'b101;
    tick;
    chk("t4_g2", a_grant, 3'b100);
    req = 3'b111;
    tick;
    req = 3'b011;
    tick;
    chk("t4_wrap", a_grant, 3'b001);
    req = 3'b001; addr0 = 8'h03;
    tick;
    chk("t5_a_rv", a_rvalid, 3'b001);
    chk("t5_a_rd", a_rdata, 8'h77);
    chk("t5_b_rv_early", b_rvalid, 3'b000);
    req = 3'b010; wren = 3'b010; addr1 = 8'hF0;
    tick;
    chk("t5_b_grant", b_grant, 3'b010);
    chk("t5_b_rv", b_rvalid, 3'b001);
    chk("t5_b_rd", b_rdata, 8'h77);
    tick;
    chk("t5_b_rv_off", b_rvalid, 3'b000);
    req = 3'b000; wren = 3'b000;
    tick;
    chk("t5_b_rv_none", b_rvalid, 3'b000);
    chk("t5_idle", a_grant, 3'b000);
    req = 3'b001; addr0 = 8'h03;
    tick;
    chk("t6_grant", b_grant, 3'b001);
    tick;
    reset = 1'b0;
    #1;
    chk("t6_a_rv", a_rvalid, 3'b000);
    chk("t6_b_rv", b_rvalid, 3'b000);
    chk("t6_a_busy", a_busy, 1'b0);
    chk("t6_b_busy", b_busy, 1'b0);
    chk("t6_grant0", a_grant, 3'b000);
    tick;
    chk("t6_b_rv_late", b_rvalid, 3'b000);
    chk("t6_b_busy_late", b_busy, 1'b0);
    reset = 1'b1; req = 3'b000;
    tick; tick;
    chk("t6_a_rv_after", a_rvalid, 3'b000);
    chk("t6_b_rv_after", b_rvalid, 3'b000);
    chk("t6_busy_after", b_busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
